// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
//   Bus-termination and interrupt stage for the 68000 bus. It sits behind the
//   address decoder and terminates each CPU cycle. A cycle ends in one of three
//   ways: DTACK_N after a per-region wait count, BERR_N from a watchdog or a
//   decoder fault, or VPA_N for an autovectored interrupt acknowledge. It also
//   synchronises the two interrupt requests and encodes them onto IPL_N.
//
// Ports
//   CLK, RST            CPU clock (rising edge); synchronous active-low reset
//   AS_N, UDS_N, LDS_N  CPU address/data strobes
//   FC[2:0]             CPU function code (3'b111 = interrupt acknowledge)
//   ADDR_L[2:0]         A3..A1; carries the acknowledged level in IACK cycles
//   SEL_*_N             active-low chip selects from the decoder
//   EXP_DTACK_N         termination from the expansion card
//   IRQ_DUART_N         asynchronous interrupt request from the DUART
//   IRQ_EXP_N           asynchronous interrupt request from the expansion bus
//   DTACK_N, BERR_N     registered termination strobes
//   VPA_N               registered autovector strobe
//   IPL_N[2:0]          registered, encoded interrupt priority level
//   IACK_DUART_N        registered DUART interrupt acknowledge
//
// Parameter ranges: BERR_TIMEOUT 8..127 and larger than every wait count;
// DUART_LEVEL and EXP_LEVEL 1..7, and the two must differ.
module bus_cycle_controller #(
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned DUART_WAIT   = 1,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter int unsigned DUART_LEVEL  = 5,
  parameter int unsigned EXP_LEVEL    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS_N,
  input  logic       UDS_N,
  input  logic       LDS_N,
  input  logic [2:0] FC,
  input  logic [2:0] ADDR_L,
  input  logic       SEL_ROM_N,
  input  logic       SEL_RAM_N,
  input  logic       SEL_DUART_N,
  input  logic       SEL_EXP_N,
  input  logic       EXP_DTACK_N,
  input  logic       IRQ_DUART_N,
  input  logic       IRQ_EXP_N,
  output logic       DTACK_N,
  output logic       BERR_N,
  output logic       VPA_N,
  output logic [2:0] IPL_N,
  output logic       IACK_DUART_N
);

  localparam logic [6:0] ROM_W     = 7'(ROM_WAIT);
  localparam logic [6:0] RAM_W     = 7'(RAM_WAIT);
  localparam logic [6:0] DUART_W   = 7'(DUART_WAIT);
  // The watchdog compares the pre-increment value, so the ERR transition
  // lands on the BERR_TIMEOUT-th edge after the count was cleared.
  localparam logic [6:0] WD_LAST   = 7'(BERR_TIMEOUT - 1);
  localparam logic [2:0] DUART_LVL = 3'(DUART_LEVEL);
  localparam logic [2:0] EXP_LVL   = 3'(EXP_LEVEL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WAIT_EXP,
    ST_IACK,
    ST_ACK,
    ST_ERR,
    ST_AVEC
  } state_t;

  state_t     state_q, state_d;
  logic       as_q, as_d;
  logic       as_prev_q, as_prev_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] wd_q, wd_d;
  logic [2:0] lvl_q, lvl_d;
  logic       dtack_n_q, dtack_n_d;
  logic       berr_n_q, berr_n_d;
  logic       vpa_n_q, vpa_n_d;
  logic       iack_n_q, iack_n_d;
  logic       irq_duart_s1_q, irq_duart_s1_d;
  logic       irq_duart_s2_q, irq_duart_s2_d;
  logic       irq_exp_s1_q, irq_exp_s1_d;
  logic       irq_exp_s2_q, irq_exp_s2_d;
  logic [2:0] ipl_n_q, ipl_n_d;

  logic       start;
  logic       iack_set;
  logic [2:0] n_sel;
  logic [2:0] best_lvl;

  always_comb begin
    state_d        = state_q;
    as_d           = AS_N;
    as_prev_d      = as_q;
    cnt_d          = cnt_q;
    wd_d           = wd_q;
    lvl_d          = lvl_q;
    irq_duart_s1_d = IRQ_DUART_N;
    irq_duart_s2_d = irq_duart_s1_q;
    irq_exp_s1_d   = IRQ_EXP_N;
    irq_exp_s2_d   = irq_exp_s1_q;
    iack_set       = 1'b0;

    // Only the first edge with as_q low qualifies, so an AS that was already
    // low while the previous cycle was finishing never starts a cycle.
    start = !as_q && as_prev_q && (!(UDS_N & LDS_N) || (FC == 3'b111));
    n_sel = {2'b00, ~SEL_ROM_N} + {2'b00, ~SEL_RAM_N}
          + {2'b00, ~SEL_DUART_N} + {2'b00, ~SEL_EXP_N};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wd_d  = '0;
          lvl_d = ADDR_L;
          if (FC == 3'b111) begin
            state_d = ST_IACK;
            if (ADDR_L == DUART_LVL) begin
              iack_set = 1'b1;
              if (DUART_W == 7'd0) state_d = ST_ACK;
            end
          end else if (n_sel > 3'd1) begin
            state_d = ST_ERR;
          end else if (!SEL_ROM_N) begin
            cnt_d   = ROM_W;
            state_d = (ROM_W == 7'd0) ? ST_ACK : ST_WAIT;
          end else if (!SEL_RAM_N) begin
            cnt_d   = RAM_W;
            state_d = (RAM_W == 7'd0) ? ST_ACK : ST_WAIT;
          end else if (!SEL_DUART_N) begin
            cnt_d   = DUART_W;
            state_d = (DUART_W == 7'd0) ? ST_ACK : ST_WAIT;
          end else begin
            // Expansion select, or nothing mapped: only EXP_DTACK_N or the
            // watchdog can end it.
            state_d = ST_WAIT_EXP;
          end
        end
      end
      ST_WAIT: begin
        wd_d  = wd_q + 7'd1;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q <= 7'd1)        state_d = ST_ACK;
        else if (wd_q == WD_LAST) state_d = ST_ERR;
      end
      ST_WAIT_EXP: begin
        wd_d = wd_q + 7'd1;
        if (!EXP_DTACK_N)         state_d = ST_ACK;
        else if (wd_q == WD_LAST) state_d = ST_ERR;
      end
      ST_IACK: begin
        // One edge in this state already counts as one DUART wait cycle.
        // The watchdog cannot expire here: it is at zero on entry.
        wd_d = wd_q + 7'd1;
        if (lvl_q == DUART_LVL) begin
          if (DUART_W <= 7'd1) begin
            state_d = ST_ACK;
          end else begin
            cnt_d   = DUART_W - 7'd1;
            state_d = ST_WAIT;
          end
        end else if (lvl_q == EXP_LVL) begin
          state_d = ST_AVEC;
        end else begin
          state_d = ST_WAIT_EXP;
        end
      end
      ST_ACK, ST_ERR, ST_AVEC: begin
        if (as_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes decode the next state, so each one appears on the same edge the
    // FSM enters its terminating state.
    dtack_n_d = (state_d != ST_ACK);
    vpa_n_d   = (state_d != ST_AVEC);
    // A decoder fault seen in IDLE reaches BERR_N one edge later, from the
    // ERR state itself.
    berr_n_d  = !((state_d == ST_ERR) && (state_q != ST_IDLE));
    if (state_d == ST_IDLE) iack_n_d = 1'b1;
    else if (iack_set)      iack_n_d = 1'b0;
    else                    iack_n_d = iack_n_q;

    best_lvl = 3'd0;
    if (!irq_duart_s2_q)                          best_lvl = DUART_LVL;
    if (!irq_exp_s2_q && (EXP_LVL > best_lvl))    best_lvl = EXP_LVL;
    ipl_n_d = ~best_lvl;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      as_q           <= 1'b1;
      as_prev_q      <= 1'b1;
      cnt_q          <= '0;
      wd_q           <= '0;
      lvl_q          <= '0;
      dtack_n_q      <= 1'b1;
      berr_n_q       <= 1'b1;
      vpa_n_q        <= 1'b1;
      iack_n_q       <= 1'b1;
      irq_duart_s1_q <= 1'b1;
      irq_duart_s2_q <= 1'b1;
      irq_exp_s1_q   <= 1'b1;
      irq_exp_s2_q   <= 1'b1;
      ipl_n_q        <= 3'b111;
    end else begin
      state_q        <= state_d;
      as_q           <= as_d;
      as_prev_q      <= as_prev_d;
      cnt_q          <= cnt_d;
      wd_q           <= wd_d;
      lvl_q          <= lvl_d;
      dtack_n_q      <= dtack_n_d;
      berr_n_q       <= berr_n_d;
      vpa_n_q        <= vpa_n_d;
      iack_n_q       <= iack_n_d;
      irq_duart_s1_q <= irq_duart_s1_d;
      irq_duart_s2_q <= irq_duart_s2_d;
      irq_exp_s1_q   <= irq_exp_s1_d;
      irq_exp_s2_q   <= irq_exp_s2_d;
      ipl_n_q        <= ipl_n_d;
    end
  end

  assign DTACK_N      = dtack_n_q;
  assign BERR_N       = berr_n_q;
  assign VPA_N        = vpa_n_q;
  assign IACK_DUART_N = iack_n_q;
  assign IPL_N        = ipl_n_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
module tb_bus_cycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       AS_N = 1'b1, UDS_N = 1'b1, LDS_N = 1'b1;
  logic [2:0] FC = 3'd0, ADDR_L = 3'd0;
  logic       SEL_ROM_N = 1'b1, SEL_RAM_N = 1'b1, SEL_DUART_N = 1'b1, SEL_EXP_N = 1'b1;
  logic       EXP_DTACK_N = 1'b1, IRQ_DUART_N = 1'b1, IRQ_EXP_N = 1'b1;
  logic       DTACK_N, BERR_N, VPA_N, IACK_DUART_N;
  logic [2:0] IPL_N;

  bus_cycle_controller dut (
    .CLK(CLK), .RST(RST), .AS_N(AS_N), .UDS_N(UDS_N), .LDS_N(LDS_N),
    .FC(FC), .ADDR_L(ADDR_L),
    .SEL_ROM_N(SEL_ROM_N), .SEL_RAM_N(SEL_RAM_N),
    .SEL_DUART_N(SEL_DUART_N), .SEL_EXP_N(SEL_EXP_N),
    .EXP_DTACK_N(EXP_DTACK_N), .IRQ_DUART_N(IRQ_DUART_N), .IRQ_EXP_N(IRQ_EXP_N),
    .DTACK_N(DTACK_N), .BERR_N(BERR_N), .VPA_N(VPA_N),
    .IPL_N(IPL_N), .IACK_DUART_N(IACK_DUART_N)
  );

  always #5 CLK = ~CLK;

  // edge_n = number of rising edges so far; outputs sampled 1 time unit later
  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // scoreboard: expected {DTACK_N,BERR_N,VPA_N,IACK_DUART_N,IPL_N} per edge
  typedef struct {
    int         e;
    string      tag;
    logic [6:0] v;
  } exp_t;
  exp_t sb[$];

  logic [2:0] cur_ipl = 3'b111;

  function automatic logic [6:0] ov(input logic d, input logic b, input logic v, input logic i);
    return {d, b, v, i, cur_ipl};
  endfunction

  task automatic push_rng(input string tag, input int e0, input int e1, input logic [6:0] v);
    for (int e = e0; e <= e1; e++) begin
      exp_t x;
      x.e = e; x.tag = tag; x.v = v;
      sb.push_back(x);
    end
  endtask

  wire [6:0] outv = {DTACK_N, BERR_N, VPA_N, IACK_DUART_N, IPL_N};

  always @(posedge CLK) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].e == edge_n) begin
        chk($sformatf("%s@%0d", sb[i].tag, edge_n), {25'd0, outv}, {25'd0, sb[i].v});
        sb.delete(i);
      end
    end
  end

  // One CPU cycle. sel = {rom,ram,duart,exp} active-low. Edge k is the first
  // edge with AS sampled low; pre_v covers k+1..k+off-1, term_v k+off..m where
  // m = k+hold is the edge that sees AS high; idle is expected at m+1, m+2.
  task automatic bus_cycle(input string tag, input logic [2:0] fc, input logic [2:0] al,
                           input logic [3:0] sel, input int off,
                           input logic [6:0] pre_v, input logic [6:0] term_v, input int hold);
    int k;
    @(negedge CLK);
    AS_N = 1'b0; UDS_N = 1'b0; LDS_N = 1'b0; FC = fc; ADDR_L = al;
    {SEL_ROM_N, SEL_RAM_N, SEL_DUART_N, SEL_EXP_N} = sel;
    k = edge_n + 1;
    push_rng({tag, "_k"}, k, k, ov(1, 1, 1, 1));
    if (off > 1) push_rng({tag, "_pre"}, k + 1, k + off - 1, pre_v);
    push_rng({tag, "_term"}, k + off, k + hold, term_v);
    push_rng({tag, "_end"}, k + hold + 1, k + hold + 2, ov(1, 1, 1, 1));
    repeat (hold) @(negedge CLK);
    AS_N = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1; FC = 3'd0; ADDR_L = 3'd0;
    {SEL_ROM_N, SEL_RAM_N, SEL_DUART_N, SEL_EXP_N} = 4'b1111;
    repeat (3) @(negedge CLK);
  endtask

  // Change one IRQ input; IPL_N follows on the third edge that samples it.
  task automatic irq_step(input string tag, input logic duart_n, input logic exp_n,
                          input logic [2:0] new_ipl);
    int e0;
    @(negedge CLK);
    IRQ_DUART_N = duart_n; IRQ_EXP_N = exp_n;
    e0 = edge_n + 1;
    push_rng({tag, "_old"}, e0, e0 + 1, ov(1, 1, 1, 1));
    cur_ipl = new_ipl;
    push_rng({tag, "_new"}, e0 + 2, e0 + 4, ov(1, 1, 1, 1));
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    int k;
    // reset state
    push_rng("reset", 1, 4, ov(1, 1, 1, 1));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    bus_cycle("ram",   3'd5, 3'd0, 4'b1011, 1,  ov(1, 1, 1, 1), ov(0, 1, 1, 1), 4);
    bus_cycle("rom",   3'd6, 3'd0, 4'b0111, 3,  ov(1, 1, 1, 1), ov(0, 1, 1, 1), 5);
    bus_cycle("duart", 3'd5, 3'd0, 4'b1101, 2,  ov(1, 1, 1, 1), ov(0, 1, 1, 1), 4);
    EXP_DTACK_N = 1'b0;
    bus_cycle("exp",   3'd5, 3'd0, 4'b1110, 2,  ov(1, 1, 1, 1), ov(0, 1, 1, 1), 4);
    EXP_DTACK_N = 1'b1;
    bus_cycle("unmap", 3'd5, 3'd0, 4'b1111, 65, ov(1, 1, 1, 1), ov(1, 0, 1, 1), 100);
    bus_cycle("decflt",3'd5, 3'd0, 4'b0011, 2,  ov(1, 1, 1, 1), ov(1, 0, 1, 1), 4);
    bus_cycle("iackd", 3'd7, 3'd5, 4'b1111, 2,  ov(1, 1, 1, 0), ov(0, 1, 1, 0), 4);
    bus_cycle("spur",  3'd7, 3'd1, 4'b1111, 65, ov(1, 1, 1, 1), ov(1, 0, 1, 1), 68);

    // interrupts
    irq_step("irq_duart", 1'b0, 1'b1, 3'b010);
    irq_step("irq_both",  1'b0, 1'b0, 3'b010);
    irq_step("irq_exp",   1'b1, 1'b0, 3'b100);
    // autovector with the expansion IRQ still pending: IPL_N stays 100
    bus_cycle("avec",  3'd7, 3'd3, 4'b1111, 2,  ov(1, 1, 1, 1), ov(1, 1, 0, 1), 4);
    irq_step("irq_none",  1'b1, 1'b1, 3'b111);

    // reset in the middle of a ROM wait, then a normal RAM cycle
    @(negedge CLK);
    AS_N = 1'b0; LDS_N = 1'b0; SEL_ROM_N = 1'b0; FC = 3'd5;
    k = edge_n + 1;
    push_rng("rst_pre", k, k + 1, ov(1, 1, 1, 1));
    push_rng("rst_abort", k + 2, k + 5, ov(1, 1, 1, 1));
    repeat (2) @(negedge CLK);
    RST = 1'b0; AS_N = 1'b1; LDS_N = 1'b1; SEL_ROM_N = 1'b1; FC = 3'd0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    bus_cycle("post_rst", 3'd5, 3'd0, 4'b1011, 1, ov(1, 1, 1, 1), ov(0, 1, 1, 1), 3);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
